uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 234, clk cycles per bit (27 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_AW, default 4, FIFO address width; depth = 2**FIFO_AW entries.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 tx_wdata  in  8  byte to transmit.
REQ-006 tx_wten  in  1  write strobe; one byte per cycle when high.
REQ-007 tx_flag_clr  in  1  clears sticky overrun/underrun flags.
REQ-008 tx_fifo_full  out  1  FIFO holds depth entries.
REQ-009 tx_fifo_overrun  out  1  sticky: a write was dropped.
REQ-010 tx_fifo_underrun  out  1  sticky: FIFO pop attempted while empty.
REQ-011 uart_tx  out  1  serial line; idle high.
REQ-012 tx_busy  out  1  high when FSM not IDLE or FIFO not empty.

Function
REQ-013 Frame SHALL be start bit (0), 8 data bits LSB first, optional parity (REQ-030), one stop bit (1); each bit held exactly CLK_DIV cycles.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE with FIFO non-empty SHALL pop one byte into the shift register and enter START on the next cycle.
REQ-016 Bit timer SHALL load CLK_DIV-1 on state/bit entry, decrement each cycle, and advance at zero.
REQ-017 START -> DATA after one bit time; DATA SHALL shift 8 bits tracked by a 3-bit index, then -> PARITY (macro on) or STOP.
REQ-018 At the final cycle of STOP: FIFO non-empty -> pop and go to START with no idle gap; else -> IDLE.
REQ-019 Latency: byte written into an empty FIFO with FSM IDLE at cycle N SHALL drive uart_tx low from cycle N+2.
REQ-020 Write while tx_fifo_full=1 SHALL be dropped and set tx_fifo_overrun, even if a pop occurs the same cycle.
REQ-021 Simultaneous write and pop on a non-full, non-empty FIFO SHALL keep occupancy unchanged.
REQ-022 Pointers SHALL be FIFO_AW+1 bits; wrap-around is modulo 2**(FIFO_AW+1); full/empty derived from MSB compare.
REQ-023 Pop while empty SHALL be ignored and set tx_fifo_underrun (guard; unreachable in correct operation).
REQ-024 tx_flag_clr SHALL clear both sticky flags next cycle; a same-cycle set event SHALL win over clear.
REQ-025 uart_tx SHALL be a registered output (glitch-free).

Reset
REQ-026 On rst_n low: uart_tx=1, tx_busy=0, tx_fifo_full=0, both flags=0, FSM=IDLE, pointers=0, timer=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (line high) and discard all FIFO contents.
REQ-028 First write after reset release SHALL be accepted normally.

Configuration
REQ-029 Macro UART_TX_PARITY_EN selects parity.
REQ-030 Defined: PARITY state transmits even parity (XOR of 8 data bits) for CLK_DIV cycles; frame = 11 bit times.
REQ-031 Undefined: PARITY state unreachable and omitted; frame = 10 bit times.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, STOP_BITS=1 and frame-length constants.
REQ-033 FIFO SHALL be sub-module uart_tx_fifo (storage, pointers, full/empty, overrun/underrun); FSM and bit timer stay in uart_tx.

Verification
REQ-034 CLK_DIV=4, write 0x55 when idle -> uart_tx low from cycle N+2, pattern 0,1,0,1,0,1,0,1,0,1 each 4 cycles, then idle high; tx_busy falls after stop.
REQ-035 Write 0xA3,0x0F back-to-back -> two frames with stop bit of first immediately followed by start of second, no gap.
REQ-036 FIFO_AW=2, write 6 bytes in 6 cycles while idle -> 4 or 5 accepted (one popped), tx_fifo_full=1, overrun=1, remaining bytes transmitted in order.
REQ-037 Assert rst_n low mid-DATA of 0xFF -> uart_tx=1 same cycle, FIFO empty, tx_busy=0; no further frame emitted.
REQ-038 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame 11*CLK_DIV cycles; undefined -> 10*CLK_DIV cycles.
REQ-039 Overrun set then tx_flag_clr pulse -> flag 0 next cycle; underrun stays 0 throughout all scenarios.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state type, frame constants and parity helper for uart_tx; PARITY state exists only under UART_TX_PARITY_EN
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte write, flag control, status and serial line of uart_tx
interface uart_tx_if;
  logic [7:0] tx_wdata;
  logic tx_wten;
  logic tx_flag_clr;
  logic tx_fifo_full;
  logic tx_fifo_overrun;
  logic tx_fifo_underrun;
  logic uart_tx;
  logic tx_busy;
  modport master (
    output tx_wdata, tx_wten, tx_flag_clr,
    input tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun, uart_tx, tx_busy
  );
  modport slave (
    input tx_wdata, tx_wten, tx_flag_clr,
    output tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun, uart_tx, tx_busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO with extra-MSB pointers and sticky overrun/underrun flags
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 wten,
  input  logic                 pop,
  input  logic                 flag_clr,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty,
  output logic                 overrun,
  output logic                 underrun
);
  logic [DATA_BITS-1:0] mem [2**AW];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr = wten && !full;
  assign rd = pop && !empty;
  assign rdata = mem[rp[AW-1:0]];
  // storage has no reset: a pointer reset already discards every entry
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= wdata;
  end
  // pointers advance on accepted write/pop; a new flag event beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      overrun <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (rd) rp <= rp + (AW+1)'(1);
      overrun <= (wten && full) || (overrun && !flag_clr);
      underrun <= (pop && empty) || (underrun && !flag_clr);
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter; defining UART_TX_PARITY_EN adds an even parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 234,
  parameter int FIFO_AW = 4
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);
  state_t state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n, rdata;
  logic line, line_n, pop, tick;
  logic empty, full, overrun, underrun;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  uart_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wdata    (bus.tx_wdata),
    .wten     (bus.tx_wten),
    .pop      (pop),
    .flag_clr (bus.tx_flag_clr),
    .rdata    (rdata),
    .full     (full),
    .empty    (empty),
    .overrun  (overrun),
    .underrun (underrun)
  );
  assign bus.tx_fifo_full = full;
  assign bus.tx_fifo_overrun = overrun;
  assign bus.tx_fifo_underrun = underrun;
  assign bus.uart_tx = line;
  assign bus.tx_busy = (state != IDLE) || !empty;
  assign tick = timer == '0;
  // next state, bit timer and shifter; the line level is derived from the next state so the register leads the state
  always_comb begin
    state_n = state;
    timer_n = tick ? BIT_LAST : timer - 16'd1;
    idx_n = idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        timer_n = empty ? '0 : BIT_LAST;
        pop = !empty;
        state_n = empty ? IDLE : START;
        shift_n = empty ? shift : rdata;
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n = '0;
      end
      DATA: if (tick) begin
        if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          idx_n = idx + 3'd1;
          shift_n = {1'b0, shift[DATA_BITS-1:1]};
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP: if (tick) begin
        pop = !empty;
        state_n = empty ? IDLE : START;
        shift_n = empty ? shift : rdata;
        timer_n = empty ? '0 : BIT_LAST;
      end
      default: state_n = IDLE;
    endcase
    line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    par_n = pop ? even_parity(rdata) : par;
    if (state_n == PARITY) line_n = par;
`endif
  end
  // state registers and the registered serial line; reset aborts any frame with the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
      line <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx <= idx_n;
      shift <= shift_n;
      line <= line_n;
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with CLK_DIV=4, FIFO_AW=2; frame length follows UART_TX_PARITY_EN
module tb_uart_tx;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic prev_line = 1'b1;
  logic [31:0] mf, mexp;
  logic mbad, mabort, saw_low;
  logic seen_under = 1'b0;

  uart_tx_if bus();

  uart_tx #(.CLK_DIV(D), .FIFO_AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {21'b0, 1'b1, ^d, d, 1'b0};
`else
    return {22'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic wr(input logic [7:0] d, input bit acc);
    bus.tx_wdata = d;
    bus.tx_wten = 1'b1;
    if (acc) sb.push_back(frame_of(d));
    @(posedge clk);
    #1;
    bus.tx_wten = 1'b0;
  endtask

  task automatic send_timed(input logic [7:0] d, input string tag);
    wr(d, 1'b1);
    @(negedge clk);
    chk({tag, "_busy_n1"}, bus.tx_busy, 1);
    chk({tag, "_line_n1"}, bus.uart_tx, 1);
    @(negedge clk);
    chk({tag, "_line_n2"}, bus.uart_tx, 0);
    repeat (NB * D - 1) @(negedge clk);
    chk({tag, "_busy_last"}, bus.tx_busy, 1);
    @(negedge clk);
    chk({tag, "_busy_done"}, bus.tx_busy, 0);
    chk({tag, "_line_idle"}, bus.uart_tx, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.tx_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, bus.tx_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) if (bus.tx_fifo_underrun) seen_under <= 1'b1;

  always begin
    @(negedge clk);
    if (rst_n && prev_line && !bus.uart_tx) begin
      mf = '0;
      mbad = 1'b0;
      mabort = 1'b0;
      for (int b = 0; b < NB; b++)
        for (int c = 0; c < D; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!rst_n) mabort = 1'b1;
          if (c == 0) mf[b] = bus.uart_tx;
          else if (bus.uart_tx != mf[b]) mbad = 1'b1;
        end
      if (!mabort) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mexp = sb.pop_front();
          chk("frame", mf, mexp);
          chk("bit_hold", 32'(mbad), 0);
        end
      end
    end
    prev_line = bus.uart_tx;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_wdata = 8'h00;
    bus.tx_wten = 1'b0;
    bus.tx_flag_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", bus.uart_tx, 1);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_full", bus.tx_fifo_full, 0);
    chk("rst_ovr", bus.tx_fifo_overrun, 0);
    chk("rst_und", bus.tx_fifo_underrun, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_timed(8'h55, "x55");
    repeat (3) @(negedge clk);

    wr(8'hA3, 1'b1);
    wr(8'h0F, 1'b1);
    @(negedge clk);
    chk("b2b_start1", bus.uart_tx, 0);
    repeat (NB * D - 1) @(negedge clk);
    chk("b2b_stop1", bus.uart_tx, 1);
    chk("b2b_busy1", bus.tx_busy, 1);
    @(negedge clk);
    chk("b2b_start2", bus.uart_tx, 0);
    repeat (NB * D - 1) @(negedge clk);
    chk("b2b_busy_last", bus.tx_busy, 1);
    @(negedge clk);
    chk("b2b_busy_done", bus.tx_busy, 0);
    repeat (3) @(negedge clk);

    wr(8'h01, 1'b1);
    wr(8'h80, 1'b1);
    wr(8'hC3, 1'b1);
    wr(8'h5A, 1'b1);
    wr(8'hFE, 1'b1);
    @(negedge clk);
    chk("ovf_full", bus.tx_fifo_full, 1);
    chk("ovf_before", bus.tx_fifo_overrun, 0);
    wr(8'h99, 1'b0);
    @(negedge clk);
    chk("ovf_set", bus.tx_fifo_overrun, 1);
    chk("ovf_full_hold", bus.tx_fifo_full, 1);
    bus.tx_flag_clr = 1'b1;
    wr(8'h77, 1'b0);
    bus.tx_flag_clr = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", bus.tx_fifo_overrun, 1);
    bus.tx_flag_clr = 1'b1;
    @(posedge clk);
    #1 bus.tx_flag_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", bus.tx_fifo_overrun, 0);
    wait_idle("ovf");

    wr(8'hFF, 1'b1);
    wr(8'h00, 1'b1);
    repeat (D + 6) @(negedge clk);
    chk("rst_mid_busy", bus.tx_busy, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_line", bus.uart_tx, 1);
    chk("rst_mid_idle", bus.tx_busy, 0);
    chk("rst_mid_full", bus.tx_fifo_full, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!bus.uart_tx) saw_low = 1'b1;
    end
    chk("rst_no_frame", saw_low, 0);
    chk("rst_busy_after", bus.tx_busy, 0);

    send_timed(8'h3C, "post_rst");
    repeat (3) @(negedge clk);
    send_timed(8'h07, "x07");
    wait_idle("end");

    chk("und_never", seen_under, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
